// File: rtl/mem_arbiter_n.sv
// N-channel arbiter onto a single tagged memory port, with per-channel load caps,
// a tag-owner table that routes returning load data, and per-channel flush of stale loads.
module mem_arbiter_n #(
  parameter int NUM_CH  = 3,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 4,
  parameter int RR_MODE = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0][1:0]        req_command,
  input  logic [NUM_CH-1:0][31:0]       req_addr,
  input  logic [NUM_CH-1:0][63:0]       req_data,
  input  logic [NUM_CH-1:0]             req_flush,
  output logic [NUM_CH-1:0][TAG_W-1:0]  grant_response,
  output logic [NUM_CH-1:0][63:0]       resp_data,
  output logic [NUM_CH-1:0][TAG_W-1:0]  resp_tag,
  output logic                          tag_error,
  input  logic [TAG_W-1:0]              mem2ctrl_response,
  input  logic [63:0]                   mem2ctrl_data,
  input  logic [TAG_W-1:0]              mem2ctrl_tag,
  output logic [1:0]                    ctrl2mem_command,
  output logic [31:0]                   ctrl2mem_addr,
  output logic [63:0]                   ctrl2mem_data
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int CNT_W    = $clog2(MAX_OUT + 1);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  logic [NUM_TAGS-1:0]            tbl_valid_r;
  logic [NUM_TAGS-1:0]            tbl_stale_r;
  logic [NUM_TAGS-1:0][CH_W-1:0]  tbl_owner_r;
  logic [NUM_CH-1:0][CNT_W-1:0]   out_cnt_r;
  logic [CH_W-1:0]                rr_ptr_r;
  logic                           tag_error_r;

  logic [NUM_CH-1:0] elig_s;
  logic [CH_W-1:0]   idx_s;
  logic [CH_W-1:0]   win_s;
  logic              win_found_s;
  logic              acc_s;
  logic              load_acc_s;
  logic              ret_hit_s;
  logic              ret_miss_s;
  logic [CH_W-1:0]   ret_owner_s;
  logic [NUM_CH-1:0] cnt_inc_s;
  logic [NUM_CH-1:0] cnt_dec_s;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (ch == CH_W'(NUM_CH - 1)) begin
      return '0;
    end else begin
      return ch + CH_W'(1);
    end
  endfunction

  // Eligibility: any command, except a load from a channel already at its cap
  always_comb begin
    elig_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (req_command[c] == CMD_NONE) begin
        elig_s[c] = 1'b0;
      end else if (req_command[c] == CMD_LOAD && out_cnt_r[c] == CNT_W'(MAX_OUT)) begin
        elig_s[c] = 1'b0;
      end else begin
        elig_s[c] = 1'b1;
      end
    end
  end

  // Winner search, starting at rr_ptr in round-robin mode or at ch0 otherwise
  always_comb begin
    win_s       = '0;
    win_found_s = 1'b0;
    idx_s       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (RR_MODE != 0) begin
        idx_s = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
      end else begin
        idx_s = CH_W'(i);
      end
      if (!win_found_s && elig_s[idx_s]) begin
        win_found_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Accept/return decode and the combinational memory-side and channel-side outputs
  always_comb begin
    acc_s            = reset_n && win_found_s && (mem2ctrl_response != '0);
    load_acc_s       = acc_s && (req_command[win_s] == CMD_LOAD);
    ret_hit_s        = (mem2ctrl_tag != '0) && tbl_valid_r[mem2ctrl_tag];
    ret_miss_s       = (mem2ctrl_tag != '0) && !tbl_valid_r[mem2ctrl_tag];
    ret_owner_s      = tbl_owner_r[mem2ctrl_tag];
    ctrl2mem_command = CMD_NONE;
    ctrl2mem_addr    = 32'd0;
    ctrl2mem_data    = 64'd0;
    grant_response   = '0;
    resp_data        = '0;
    resp_tag         = '0;
    cnt_inc_s        = '0;
    cnt_dec_s        = '0;
    if (reset_n && win_found_s) begin
      ctrl2mem_command      = req_command[win_s];
      ctrl2mem_addr         = req_addr[win_s];
      ctrl2mem_data         = req_data[win_s];
      grant_response[win_s] = mem2ctrl_response;
    end else begin
      ctrl2mem_command = CMD_NONE;
    end
    // stale entries are still freed, but their data never reaches the channel
    if (reset_n && ret_hit_s && !tbl_stale_r[mem2ctrl_tag]) begin
      resp_tag[ret_owner_s]  = mem2ctrl_tag;
      resp_data[ret_owner_s] = mem2ctrl_data;
    end else begin
      resp_tag = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_inc_s[c] = load_acc_s && (win_s == CH_W'(c));
      cnt_dec_s[c] = ret_hit_s && (ret_owner_s == CH_W'(c));
    end
  end

  assign tag_error = tag_error_r;

  // Tag table: flush marks stale, then a return frees, then an accept allocates
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbl_valid_r <= '0;
      tbl_stale_r <= '0;
      tbl_owner_r <= '0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (tbl_valid_r[t] && req_flush[tbl_owner_r[t]]) begin
          tbl_stale_r[t] <= 1'b1;
        end
      end
      if (ret_hit_s) begin
        tbl_valid_r[mem2ctrl_tag] <= 1'b0;
        tbl_stale_r[mem2ctrl_tag] <= 1'b0;
      end
      if (load_acc_s) begin
        tbl_valid_r[mem2ctrl_response] <= 1'b1;
        tbl_stale_r[mem2ctrl_response] <= 1'b0;
        tbl_owner_r[mem2ctrl_response] <= win_s;
      end
    end
  end

  // Outstanding-load counters, round-robin pointer and sticky tag error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_r   <= '0;
      rr_ptr_r    <= '0;
      tag_error_r <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_inc_s[c] && !cnt_dec_s[c]) begin
          out_cnt_r[c] <= out_cnt_r[c] + CNT_W'(1);
        end else if (cnt_dec_s[c] && !cnt_inc_s[c]) begin
          out_cnt_r[c] <= out_cnt_r[c] - CNT_W'(1);
        end
      end
      if (acc_s) begin
        rr_ptr_r <= next_ch(win_s);
      end
      if (ret_miss_s) begin
        tag_error_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench: a round-robin instance with MAX_OUT=2 and a fixed-priority instance,
// both fed the same stimulus; each scenario checks only the instance it targets.
module tb_mem_arbiter_n;
  localparam int NUM_CH = 3;
  localparam int TAG_W  = 4;
  localparam logic [1:0] LD = 2'd1;
  localparam logic [1:0] ST = 2'd2;

  logic clock;
  logic reset_n;
  logic [NUM_CH-1:0][1:0]  req_command;
  logic [NUM_CH-1:0][31:0] req_addr;
  logic [NUM_CH-1:0][63:0] req_data;
  logic [NUM_CH-1:0]       req_flush;
  logic [TAG_W-1:0]        mem2ctrl_response;
  logic [63:0]             mem2ctrl_data;
  logic [TAG_W-1:0]        mem2ctrl_tag;

  logic [NUM_CH-1:0][TAG_W-1:0] rr_grant, fp_grant, rr_rtag, fp_rtag;
  logic [NUM_CH-1:0][63:0]      rr_rdata, fp_rdata;
  logic                         rr_terr, fp_terr;
  logic [1:0]                   rr_cmd, fp_cmd;
  logic [31:0]                  rr_addr, fp_addr;
  logic [63:0]                  rr_data, fp_data;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter_n #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .MAX_OUT(2), .RR_MODE(1)) u_rr (
    .clock(clock), .reset_n(reset_n), .req_command(req_command), .req_addr(req_addr),
    .req_data(req_data), .req_flush(req_flush), .grant_response(rr_grant),
    .resp_data(rr_rdata), .resp_tag(rr_rtag), .tag_error(rr_terr),
    .mem2ctrl_response(mem2ctrl_response), .mem2ctrl_data(mem2ctrl_data),
    .mem2ctrl_tag(mem2ctrl_tag), .ctrl2mem_command(rr_cmd), .ctrl2mem_addr(rr_addr),
    .ctrl2mem_data(rr_data));

  mem_arbiter_n #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .MAX_OUT(4), .RR_MODE(0)) u_fp (
    .clock(clock), .reset_n(reset_n), .req_command(req_command), .req_addr(req_addr),
    .req_data(req_data), .req_flush(req_flush), .grant_response(fp_grant),
    .resp_data(fp_rdata), .resp_tag(fp_rtag), .tag_error(fp_terr),
    .mem2ctrl_response(mem2ctrl_response), .mem2ctrl_data(mem2ctrl_data),
    .mem2ctrl_tag(mem2ctrl_tag), .ctrl2mem_command(fp_cmd), .ctrl2mem_addr(fp_addr),
    .ctrl2mem_data(fp_data));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    req_command       = '0;
    req_flush         = '0;
    mem2ctrl_response = '0;
    mem2ctrl_tag      = '0;
    mem2ctrl_data     = '0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    clear_in();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    req_addr[0] = 32'h1000; req_addr[1] = 32'h2000; req_addr[2] = 32'h3000;
    req_data[0] = 64'hD0;   req_data[1] = 64'hD1;   req_data[2] = 64'hD2;
    clear_in();
    reset_n = 1'b0;
    req_command[0] = LD; mem2ctrl_response = 4'd1; mem2ctrl_tag = 4'd7;
    #1;
    chk("rst_cmd", 64'(rr_cmd), 64'h0);
    chk("rst_grant", 64'(rr_grant), 64'h0);
    chk("rst_rtag", 64'(rr_rtag), 64'h0);
    chk("rst_terr", 64'(rr_terr), 64'h0);
    tick(); tick();
    reset_n = 1'b1;
    clear_in();
    #1;

    // 1: round-robin rotation across all three loading channels
    req_command = {LD, LD, LD};
    mem2ctrl_response = 4'd1; #1;
    chk("t1_grant0", 64'(rr_grant), 64'h001);
    chk("t1_addr0", 64'(rr_addr), 64'h1000);
    tick();
    mem2ctrl_response = 4'd2; #1;
    chk("t1_grant1", 64'(rr_grant), 64'h020);
    chk("t1_addr1", 64'(rr_addr), 64'h2000);
    tick();
    mem2ctrl_response = 4'd3; #1;
    chk("t1_grant2", 64'(rr_grant), 64'h300);
    tick();
    clear_in();
    mem2ctrl_tag = 4'd2; mem2ctrl_data = 64'hAAAA; #1;
    chk("t1_ret2_tag", 64'(rr_rtag), 64'h020);
    chk("t1_ret2_data", rr_rdata[1], 64'hAAAA);
    tick();
    mem2ctrl_tag = 4'd3; #1;
    chk("t1_ret3_tag", 64'(rr_rtag), 64'h300);
    tick();
    mem2ctrl_tag = 4'd1; #1;
    chk("t1_ret1_tag", 64'(rr_rtag), 64'h001);
    tick();
    clear_in(); #1;
    chk("t1_terr", 64'(rr_terr), 64'h0);
    chk("t1_cnt", 64'(u_rr.out_cnt_r), 64'h0);

    // 3: per-channel cap with MAX_OUT=2
    reset_dut();
    req_command[0] = LD; mem2ctrl_response = 4'd1; #1;
    chk("t3_grant_a", 64'(rr_grant), 64'h001);
    tick();
    mem2ctrl_response = 4'd2; #1;
    chk("t3_grant_b", 64'(rr_grant), 64'h002);
    tick();
    mem2ctrl_response = 4'd0; #1;
    chk("t3_capped", 64'(rr_cmd), 64'h0);
    req_command[1] = LD; #1;
    chk("t3_ch1_wins", 64'(rr_addr), 64'h2000);
    req_command[1] = 2'd0; mem2ctrl_tag = 4'd1; #1;
    chk("t3_still_capped", 64'(rr_cmd), 64'h0);
    chk("t3_ret_tag", 64'(rr_rtag), 64'h001);
    tick();
    mem2ctrl_tag = 4'd0; #1;
    chk("t3_reenabled_cmd", 64'(rr_cmd), 64'h1);
    chk("t3_reenabled_addr", 64'(rr_addr), 64'h1000);

    // 2: fixed priority, ch1 held through rejections, then ch2 served
    reset_dut();
    req_command[1] = LD; req_command[2] = ST; #1;
    chk("t2_c1_addr", 64'(fp_addr), 64'h2000);
    chk("t2_c1_grant", 64'(fp_grant), 64'h0);
    tick();
    chk("t2_c2_addr", 64'(fp_addr), 64'h2000);
    tick();
    mem2ctrl_response = 4'd5; #1;
    chk("t2_c3_grant", 64'(fp_grant), 64'h050);
    tick();
    req_command[1] = 2'd0; mem2ctrl_response = 4'd0; #1;
    chk("t2_ch2_cmd", 64'(fp_cmd), 64'h2);
    chk("t2_ch2_addr", 64'(fp_addr), 64'h3000);
    chk("t2_ch2_data", fp_data, 64'hD2);

    // 4: flushed load's return is dropped; flush coincident with return still delivers
    reset_dut();
    req_command[1] = LD; mem2ctrl_response = 4'd4; #1;
    chk("t4_grant", 64'(rr_grant), 64'h040);
    tick();
    clear_in(); req_flush = 3'b010;
    tick();
    req_flush = 3'b000; mem2ctrl_tag = 4'd4; mem2ctrl_data = 64'hDEAD; #1;
    chk("t4_stale_rtag", 64'(rr_rtag), 64'h0);
    tick();
    clear_in(); #1;
    chk("t4_cnt1", 64'(u_rr.out_cnt_r[1]), 64'h0);
    chk("t4_terr", 64'(rr_terr), 64'h0);
    req_command[2] = LD; mem2ctrl_response = 4'd6;
    tick();
    clear_in(); req_flush = 3'b100; mem2ctrl_tag = 4'd6; mem2ctrl_data = 64'hBEEF; #1;
    chk("t4_flushret_tag", 64'(rr_rtag), 64'h600);
    chk("t4_flushret_data", rr_rdata[2], 64'hBEEF);
    tick();
    clear_in();

    // 5: unowned return sets sticky error; same-tag return and accept in one cycle
    mem2ctrl_tag = 4'd7; #1;
    chk("t5_unowned_rtag", 64'(rr_rtag), 64'h0);
    tick();
    clear_in(); #1;
    chk("t5_terr_set", 64'(rr_terr), 64'h1);
    tick();
    chk("t5_terr_sticky", 64'(rr_terr), 64'h1);
    req_command[0] = LD; mem2ctrl_response = 4'd3;
    tick();
    req_command[0] = 2'd0; req_command[2] = LD;
    mem2ctrl_response = 4'd3; mem2ctrl_tag = 4'd3; mem2ctrl_data = 64'h1234; #1;
    chk("t5_old_owner", 64'(rr_rtag), 64'h003);
    chk("t5_new_grant", 64'(rr_grant), 64'h300);
    tick();
    clear_in(); mem2ctrl_tag = 4'd3; mem2ctrl_data = 64'h5678; #1;
    chk("t5_new_owner", 64'(rr_rtag), 64'h300);
    chk("t5_new_data", rr_rdata[2], 64'h5678);
    tick();
    clear_in(); #1;
    chk("t5_cnt", 64'(u_rr.out_cnt_r), 64'h0);

    // 6: reset mid-stream with three loads outstanding
    req_command[0] = LD; mem2ctrl_response = 4'd1; tick();
    req_command = {2'd0, LD, 2'd0}; mem2ctrl_response = 4'd2; tick();
    req_command = {LD, 2'd0, 2'd0}; mem2ctrl_response = 4'd8; tick();
    clear_in(); #1;
    chk("t6_cnt_pre", 64'(u_rr.out_cnt_r), 64'h15);
    req_command = {LD, LD, LD}; mem2ctrl_response = 4'd5; mem2ctrl_tag = 4'd1; #1;
    chk("t6_pre_rtag", 64'(rr_rtag), 64'h001);
    reset_n = 1'b0; #1;
    chk("t6_rst_cmd", 64'(rr_cmd), 64'h0);
    chk("t6_rst_grant", 64'(rr_grant), 64'h0);
    chk("t6_rst_rtag", 64'(rr_rtag), 64'h0);
    chk("t6_rst_terr", 64'(rr_terr), 64'h0);
    tick();
    reset_n = 1'b1; clear_in(); #1;
    chk("t6_cnt_post", 64'(u_rr.out_cnt_r), 64'h0);
    chk("t6_ptr_post", 64'(u_rr.rr_ptr_r), 64'h0);
    req_command = {LD, LD, LD}; #1;
    chk("t6_first_win", 64'(rr_addr), 64'h1000);
    clear_in(); mem2ctrl_tag = 4'd1;
    tick();
    clear_in(); #1;
    chk("t6_table_cleared", 64'(rr_terr), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
